// File: rtl/spm_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spm_dp_pkg
// Purpose  : Shared encodings for the dual-port scratchpad: request
//            direction (READ/WRITE), active-low strobe levels
//            (ENABLE_/DISABLE_) and the controller state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package spm_dp_pkg;

    // Request direction on *_spm_rw
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    // Active-low strobe / ready levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Controller states
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage : spm_dp_pkg
`default_nettype wire

// File: rtl/spm_bank.sv
`default_nettype none
// ============================================================================
// Module   : spm_bank
// Purpose  : True dual-port storage array with per-byte write enables and a
//            registered read on each port. A port's read register only
//            updates when that port's read enable is set, so read data holds
//            between reads. Only the read registers are reset; the array
//            itself has no reset.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_a_* / i_b_*       - address, byte write enables, write data,
//                                  read enable
//            o_a_rd / o_b_rd     - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module spm_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [BE_W-1:0]   i_a_we,
    input  logic [DATA_W-1:0] i_a_wd,
    input  logic              i_a_re,
    output logic [DATA_W-1:0] o_a_rd,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [BE_W-1:0]   i_b_we,
    input  logic [DATA_W-1:0] i_b_wd,
    input  logic              i_b_re,
    output logic [DATA_W-1:0] o_b_rd
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_a_rd;
    logic [DATA_W-1:0] r_b_rd;

    // Both ports write from one process; the controller never lets the two
    // ports write the same word in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (i_a_we[i]) r_mem[i_a_addr][i*8 +: 8] <= i_a_wd[i*8 +: 8];
            if (i_b_we[i]) r_mem[i_b_addr][i*8 +: 8] <= i_b_wd[i*8 +: 8];
        end
    end

    // Read registers return the pre-write contents; the controller patches
    // in same-cycle cross-port writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_rd <= '0;
            r_b_rd <= '0;
        end else begin
            if (i_a_re) r_a_rd <= r_mem[i_a_addr];
            if (i_b_re) r_b_rd <= r_mem[i_b_addr];
        end
    end

    assign o_a_rd = r_a_rd;
    assign o_b_rd = r_b_rd;

endmodule : spm_bank
`default_nettype wire

// File: rtl/spm_dp.sv
`default_nettype none
// ============================================================================
// Module   : spm_dp
// Purpose  : Dual-port scratchpad controller. Zero-fills the array after
//            reset (optional), arbitrates same-address write collisions
//            (MEM wins, a stalled IF write wins the following collision),
//            and forwards same-cycle cross-port writes into reads
//            (write-first, byte-merged).
// Ports    : clk, reset          - clock, synchronous active-high reset
//            if_spm_*            - port A: addr, as_, rw, be, wr_data,
//                                  rd_data, rdy_
//            mem_spm_*           - port B: same set as port A
// Revision : 1.0 - initial release
// ============================================================================
module spm_dp
    import spm_dp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int CLR_EN = 1,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    // Port A (IF)
    input  logic [ADDR_W-1:0] if_spm_addr,
    input  logic              if_spm_as_,
    input  logic              if_spm_rw,
    input  logic [BE_W-1:0]   if_spm_be,
    input  logic [DATA_W-1:0] if_spm_wr_data,
    output logic [DATA_W-1:0] if_spm_rd_data,
    output logic              if_spm_rdy_,
    // Port B (MEM)
    input  logic [ADDR_W-1:0] mem_spm_addr,
    input  logic              mem_spm_as_,
    input  logic              mem_spm_rw,
    input  logic [BE_W-1:0]   mem_spm_be,
    input  logic [DATA_W-1:0] mem_spm_wr_data,
    output logic [DATA_W-1:0] mem_spm_rd_data,
    output logic              mem_spm_rdy_
);

    localparam logic [0:0] c_RESET_STATE = (CLR_EN != 0) ? ST_CLEAR : ST_READY;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_if_stalled;
    logic [BE_W-1:0]   r_if_fwd_be;
    logic [DATA_W-1:0] r_if_fwd_data;
    logic [BE_W-1:0]   r_mem_fwd_be;
    logic [DATA_W-1:0] r_mem_fwd_data;

    logic              w_clear;
    logic              w_if_req, w_mem_req;
    logic              w_if_wr, w_mem_wr;
    logic              w_ww_col;
    logic              w_if_rdy_n, w_mem_rdy_n;
    logic              w_if_acc, w_mem_acc;
    logic              w_if_acc_wr, w_if_acc_rd;
    logic              w_mem_acc_wr, w_mem_acc_rd;
    logic              w_same_addr;

    logic [ADDR_W-1:0] w_a_addr;
    logic [BE_W-1:0]   w_a_we;
    logic [DATA_W-1:0] w_a_wd;
    logic [BE_W-1:0]   w_b_we;
    logic [DATA_W-1:0] w_a_rd;
    logic [DATA_W-1:0] w_b_rd;

    assign w_clear     = (r_state == ST_CLEAR);
    assign w_same_addr = (if_spm_addr == mem_spm_addr);
    assign w_if_req    = (if_spm_as_  == ENABLE_);
    assign w_mem_req   = (mem_spm_as_ == ENABLE_);
    assign w_if_wr     = w_if_req  && (if_spm_rw  == WRITE);
    assign w_mem_wr    = w_mem_req && (mem_spm_rw == WRITE);
    assign w_ww_col    = w_if_wr && w_mem_wr && w_same_addr;

    // Ready is purely combinational. MEM normally wins a write collision;
    // if IF was stalled last cycle it takes the next collision so it cannot
    // be starved by MEM re-hitting the same word.
    always_comb begin
        w_if_rdy_n  = ENABLE_;
        w_mem_rdy_n = ENABLE_;
        if (w_clear) begin
            w_if_rdy_n  = DISABLE_;
            w_mem_rdy_n = DISABLE_;
        end else if (w_ww_col) begin
            if (r_if_stalled) begin
                w_mem_rdy_n = DISABLE_;
            end else begin
                w_if_rdy_n  = DISABLE_;
            end
        end
    end

    assign if_spm_rdy_  = w_if_rdy_n;
    assign mem_spm_rdy_ = w_mem_rdy_n;

    assign w_if_acc     = w_if_req  && (w_if_rdy_n  == ENABLE_);
    assign w_mem_acc    = w_mem_req && (w_mem_rdy_n == ENABLE_);
    assign w_if_acc_wr  = w_if_acc  && (if_spm_rw  == WRITE);
    assign w_if_acc_rd  = w_if_acc  && (if_spm_rw  == READ);
    assign w_mem_acc_wr = w_mem_acc && (mem_spm_rw == WRITE);
    assign w_mem_acc_rd = w_mem_acc && (mem_spm_rw == READ);

    // Port A doubles as the zero-fill write port while clearing.
    assign w_a_addr = w_clear ? r_clr_cnt : if_spm_addr;
    assign w_a_we   = w_clear ? {BE_W{1'b1}} :
                      (w_if_acc_wr ? if_spm_be : {BE_W{1'b0}});
    assign w_a_wd   = w_clear ? {DATA_W{1'b0}} : if_spm_wr_data;
    assign w_b_we   = w_mem_acc_wr ? mem_spm_be : {BE_W{1'b0}};

    spm_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .BE_W   (BE_W)
    ) u_bank (
        .clk      (clk),
        .rst      (reset),
        .i_a_addr (w_a_addr),
        .i_a_we   (w_a_we),
        .i_a_wd   (w_a_wd),
        .i_a_re   (w_if_acc_rd),
        .o_a_rd   (w_a_rd),
        .i_b_addr (mem_spm_addr),
        .i_b_we   (w_b_we),
        .i_b_wd   (mem_spm_wr_data),
        .i_b_re   (w_mem_acc_rd),
        .o_b_rd   (w_b_rd)
    );

    // Controller state, clear counter and collision history
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_RESET_STATE;
            r_clr_cnt    <= '0;
            r_if_stalled <= 1'b0;
        end else begin
            r_if_stalled <= !w_clear && w_ww_col && (w_if_rdy_n == DISABLE_);
            if (w_clear) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
                if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    r_state <= ST_READY;
                end
            end
        end
    end

    // Forwarding capture: when a read is accepted, remember which lanes the
    // other port wrote to the same word in that same cycle (zero if none).
    // Captured only on accepted reads, so merged read data holds as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_fwd_be    <= '0;
            r_if_fwd_data  <= '0;
            r_mem_fwd_be   <= '0;
            r_mem_fwd_data <= '0;
        end else begin
            if (w_if_acc_rd) begin
                r_if_fwd_be   <= (w_mem_acc_wr && w_same_addr) ? mem_spm_be : {BE_W{1'b0}};
                r_if_fwd_data <= mem_spm_wr_data;
            end
            if (w_mem_acc_rd) begin
                r_mem_fwd_be   <= (w_if_acc_wr && w_same_addr) ? if_spm_be : {BE_W{1'b0}};
                r_mem_fwd_data <= if_spm_wr_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
            assign if_spm_rd_data[gi*8 +: 8]  = r_if_fwd_be[gi]  ? r_if_fwd_data[gi*8 +: 8]
                                                                 : w_a_rd[gi*8 +: 8];
            assign mem_spm_rd_data[gi*8 +: 8] = r_mem_fwd_be[gi] ? r_mem_fwd_data[gi*8 +: 8]
                                                                 : w_b_rd[gi*8 +: 8];
        end
    endgenerate

endmodule : spm_dp
`default_nettype wire
